// File: rtl/fa_bist_pkg.sv
// fa_bist_pkg: shared state encoding, sweep constants and golden full-adder model
package fa_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;
  localparam int NUM_VECTORS = 8;
  localparam int VEC_W = 3;
  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {1'b0, cin};
  endfunction
endpackage

// File: rtl/fa_bist_checker.sv
// fa_bist_checker: compares adder response to golden model, tracks mismatch count and first failing vector
module fa_bist_checker
  import fa_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [VEC_W-1:0] vec,
  input  logic             sum,
  input  logic             cout,
  output logic [3:0]       fail_count,
  output logic [VEC_W-1:0] first_fail_vec
);
  logic [3:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic miss;
  always_comb begin
    miss = en && ({cout, sum} != fa_golden(vec[0], vec[1], vec[2]));
    cnt_d = clr ? '0 : (miss && cnt_q != 4'(NUM_VECTORS)) ? cnt_q + 4'd1 : cnt_q;
    ffv_d = clr ? '0 : (miss && cnt_q == '0) ? vec : ffv_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ffv_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ffv_q <= ffv_d;
    end
  end
  assign fail_count = cnt_q;
  assign first_fail_vec = ffv_q;
endmodule

// File: rtl/fulladder_bist.sv
// fulladder_bist: sweeps all eight full-adder input vectors, holds each for a settle window,
// and reports pass/fail, mismatch count and first failing vector.
module fulladder_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_count,
  output logic [VEC_W-1:0] first_fail_vec
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] v_q, v_d;
  logic go;
  always_comb begin
    go = start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    cnt_d = cnt_q;
    v_d = v_q;
    if (go) begin
      state_d = SETTLE;
      cnt_d = RELOAD;
      v_d = '0;
    end else if (state_q == SETTLE) begin
      state_d = (cnt_q == '0) ? CHECK : SETTLE;
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    end else if (state_q == CHECK) begin
      state_d = (v_q == VEC_W'(NUM_VECTORS - 1)) ? DONE : SETTLE;
      v_d = (v_q == VEC_W'(NUM_VECTORS - 1)) ? v_q : v_q + VEC_W'(1);
      cnt_d = RELOAD;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      v_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      v_q <= v_d;
    end
  end
  // stimulus comes straight from the vector register, so a toggles fastest
  assign {cin, b, a} = v_q;
  assign busy = (state_q == SETTLE) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (fail_count == '0);
  fa_bist_checker u_checker (
    .clk           (clk),
    .rst           (rst),
    .clr           (go),
    .en            (state_q == CHECK),
    .vec           (v_q),
    .sum           (sum),
    .cout          (cout),
    .fail_count    (fail_count),
    .first_fail_vec(first_fail_vec)
  );
endmodule

// File: doc/fulladder_bist.md
# fulladder_bist

Synthesizable built-in self-test for the `fulladder` cell: the hardware initiator that drives the adder's `a`/`b`/`cin` inputs and checks its `sum`/`cout` responses. It sweeps all eight input vectors in a fixed order, holds each vector for a programmable settle window, and compares the adder outputs against a golden model. It reports pass/fail, a mismatch count and the first failing vector. It sits beside any `fulladder` instance (or a chain of them) as a power-on or on-demand self-check.

## Interface
- `SETTLE_CYCLES`, default 2: number of cycles each vector is held before sampling; legal range ≥1.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: start request; sampled only in IDLE and DONE.
- `a`, `b`, `cin` output 1 each: registered stimulus to the DUT.
- `sum`, `cout` input 1 each: DUT response.
- `busy` output 1: high from sweep start until DONE is entered.
- `done` output 1: held high in DONE until the next start or reset.
- `pass` output 1: valid while `done`=1; high iff `fail_count`==0.
- `fail_count` output 4: number of mismatching vectors, 0..8.
- `first_fail_vec` output 3: index of the first mismatching vector; meaningful only when `fail_count`≠0.

## Operation
- Vector index `v` (3 bits) maps to outputs as {`cin`,`b`,`a`} = `v`, so `a` toggles fastest. The sweep order is 0→7.
- Golden model: {`cout_exp`,`sum_exp`} = `a`+`b`+`cin` (2-bit result).
- States:
  - IDLE: outputs low. `start`=1 → SETTLE, with `v`=0, `fail_count`=0, `first_fail_vec`=0, settle counter = SETTLE_CYCLES-1.
  - SETTLE: counter decrements each cycle; when it reaches 0 → CHECK.
  - CHECK: one cycle. Compare {`cout`,`sum`} against the expected value.
    - On mismatch: `fail_count`++. If it was 0, `first_fail_vec`=`v`.
    - If `v`==7 → DONE; otherwise `v`++, reload the counter, → SETTLE.
  - DONE: `done`=1, `busy`=0, stimulus held at vector 7, results frozen. `start`=1 → restart exactly as from IDLE (results cleared).
- `start` is ignored while `busy`=1.
- `fail_count` cannot wrap: its maximum is 8.

## Timing
- Reset values: `a`=`b`=`cin`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_vec`=0, state IDLE.
- Start accepted at edge k:
  - Vector 0 appears on `a`/`b`/`cin` and `busy`=1 after edge k.
  - Each vector is driven for exactly SETTLE_CYCLES+1 cycles.
  - The DUT response is sampled at the final edge of each vector's window, i.e. combinational DUT paths see ≥SETTLE_CYCLES full cycles.
- `done`=1 and `busy`=0 after edge k+8·(SETTLE_CYCLES+1). `pass`, `fail_count` and `first_fail_vec` are final in that same cycle.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronous); the next sweep needs a fresh `start`.
- `start` together with reset deassertion in the same cycle: reset has priority; `start` is seen only on the following edge.

## Structure
- Package `fa_bist_pkg` contains:
  - state enum {IDLE, SETTLE, CHECK, DONE}
  - `NUM_VECTORS`=8 and `VEC_W`=3
  - function `fa_golden(a,b,cin)` returning the 2-bit {cout,sum}
- One sub-module is natural: `fa_bist_checker`, which holds the compare, `fail_count` and first-fail capture, enabled by CHECK.
- FSM, settle counter and vector register live in the top module.

## Test plan
- Correct `fulladder` attached, SETTLE_CYCLES=2, `start` pulse at edge k → `done`=1 at k+24, `pass`=1, `fail_count`=0.
- DUT `sum` stuck at 0 → vectors 1, 2, 4, 7 fail; `fail_count`=4, `first_fail_vec`=1, `pass`=0.
- DUT `cout` inverted → all 8 vectors fail; `fail_count`=8, `first_fail_vec`=0.
- Assert `rst` while `v`=3 → all outputs 0 at once, state IDLE; a following `start` completes with `pass`=1.
- `start` held high during the sweep → sweep unaffected and `done` at k+24. A `start` issued in DONE restarts: `done`=0, `fail_count`=0, `a`/`b`/`cin`=0 on the next cycle.
- SETTLE_CYCLES=1 → each vector is held 2 cycles; `done` at k+16.
